// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the AHB-to-APB bridge.
// Holds the master FSM state encoding, HRESP codes and default bus widths.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } apb_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int APB_ADDR_W_DEF      = 32;
  localparam int APB_DATA_W_DEF      = 32;
  localparam int APB_NUM_SLV_DEF     = 3;
  localparam int APB_TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired is high once TIMEOUT_CYC-1 stalled cycles are counted.
// Latency: expired follows the registered count combinationally.
// Backpressure: none; clr restarts the count, inc advances it and it saturates at the limit.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic Hclk,
  input  logic Hresetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_fsm_gen.sv
// APB3 master sequencer for the AHB bridge; optional ACCESS timeout under APB_TIMEOUT_EN.
// Latency: read 2, write 3 Hreadyout-low cycles plus one per Pready-low cycle; errors add ERR1.
// Backpressure: Hreadyout low while busy; valid only sampled in IDLE/ERR2; Pready stalls ACCESS.
module apb_master_fsm_gen
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W_DEF,
  parameter int DATA_W      = APB_DATA_W_DEF,
  parameter int NUM_SLV     = APB_NUM_SLV_DEF,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC_DEF
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic               valid,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic               Hwrite,
  input  logic [DATA_W-1:0]  Hwdata,
  input  logic [NUM_SLV-1:0] tempselx,
  output logic               Hreadyout,
  output logic               Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  output logic [ADDR_W-1:0]  Paddr,
  output logic               Pwrite,
  output logic [DATA_W-1:0]  Pwdata,
  output logic [NUM_SLV-1:0] Pselx,
  output logic               Penable,
  input  logic               Pready,
  input  logic               Pslverr,
  input  logic [DATA_W-1:0]  Prdata
);

  apb_state_e         state;
  logic [NUM_SLV-1:0] sel_q;
  logic               tmo_expired;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .clr     (state == ST_SETUP),
    .inc     ((state == ST_ACCESS) && !Pready),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
      Hrdata    <= '0;
      Paddr     <= '0;
      Pwrite    <= 1'b0;
      Pwdata    <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      sel_q     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (valid) begin
            Paddr     <= Haddr;
            Pwrite    <= Hwrite;
            sel_q     <= tempselx;
            Hreadyout <= 1'b0;
            if (tempselx == '0) begin
              // Address decoded to no slave: answer with ERROR, no APB cycle
              state <= ST_ERR1;
              Hresp <= HRESP_ERROR;
            end else begin
              Hresp <= HRESP_OKAY;
              if (Hwrite) begin
                state <= ST_WWAIT;
              end else begin
                state <= ST_SETUP;
                Pselx <= tempselx;
              end
            end
          end else begin
            state     <= ST_IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
          end
        end
        ST_WWAIT: begin
          Pwdata <= Hwdata;
          Pselx  <= sel_q;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          Penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (Pready) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            if (Pslverr) begin
              state <= ST_ERR1;
              Hresp <= HRESP_ERROR;
            end else begin
              state     <= ST_IDLE;
              Hreadyout <= 1'b1;
              if (!Pwrite) Hrdata <= Prdata;
            end
          end else if (tmo_expired) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            state   <= ST_ERR1;
            Hresp   <= HRESP_ERROR;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          Hreadyout <= 1'b1;
          Hresp     <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          Hreadyout <= 1'b1;
          Hresp     <= HRESP_OKAY;
          Pselx     <= '0;
          Penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm_gen.sv
// Directed plus randomized transfers against a per-transfer latency/response model.
module tb_apb_master_fsm_gen;

  localparam int TMO = 4;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic [2:0]  tempselx;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pready;
  logic        Pslverr;
  logic [31:0] Prdata;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] model_rdata = '0;

  apb_master_fsm_gen #(.TIMEOUT_CYC(TMO)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite),
    .Hwdata(Hwdata), .tempselx(tempselx), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .Paddr(Paddr), .Pwrite(Pwrite), .Pwdata(Pwdata), .Pselx(Pselx),
    .Penable(Penable), .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
  );

  always #5 Hclk = ~Hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, 32'(Hreadyout), 32'd1);
    chk({tag, "_hresp"},     32'(Hresp),     32'd0);
    chk({tag, "_hrdata"},    Hrdata,         32'd0);
    chk({tag, "_paddr"},     Paddr,          32'd0);
    chk({tag, "_pwdata"},    Pwdata,         32'd0);
    chk({tag, "_pwrite"},    32'(Pwrite),    32'd0);
    chk({tag, "_pselx"},     32'(Pselx),     32'd0);
    chk({tag, "_penable"},   32'(Penable),   32'd0);
  endtask

  // Issues one transfer starting in a cycle where Hreadyout is high and
  // returns in the completion cycle (Hreadyout high again).
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [2:0] sel,
                     input logic [31:0] wd, input int waits, input bit err,
                     input logic [31:0] rd);
    bit dec_err, tmo, resp_err, done;
    int eff_waits, exp_low, exp_sel, exp_en;
    int low, sel_cyc, en_cyc, resp_low, acc;
    dec_err = (sel == 3'b000);
`ifdef APB_TIMEOUT_EN
    tmo = !dec_err && (waits >= TMO);
`else
    tmo = 1'b0;
`endif
    eff_waits = tmo ? TMO - 1 : waits;
    resp_err  = dec_err || tmo || err;
    exp_low   = dec_err ? 1 : (wr ? 3 : 2) + eff_waits + (resp_err ? 1 : 0);
    exp_sel   = dec_err ? 0 : 2 + eff_waits;
    exp_en    = dec_err ? 0 : 1 + eff_waits;
    if (!wr && !resp_err) model_rdata = rd;

    valid = 1'b1; Haddr = addr; Hwrite = wr; tempselx = sel;
    Pready = 1'b0; Pslverr = 1'b0;
    @(posedge Hclk); #1;
    valid = 1'b0; Hwdata = wd; Haddr = $urandom; tempselx = 3'($urandom);
    low = 0; sel_cyc = 0; en_cyc = 0; resp_low = 0; acc = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (Hreadyout) begin
        done = 1'b1;
      end else begin
        low++;
        if (Hresp) resp_low++;
        chk("pselx_onehot", 32'((Pselx == 3'b000) || (Pselx == sel)), 32'd1);
        chk("penable_needs_sel", 32'(!Penable || (Pselx != 3'b000)), 32'd1);
        if (Pselx != 3'b000) begin
          sel_cyc++;
          if (sel_cyc == 1) chk("setup_penable", 32'(Penable), 32'd0);
          chk("paddr", Paddr, addr);
          chk("pwrite", 32'(Pwrite), 32'(wr));
          if (wr) chk("pwdata", Pwdata, wd);
        end
        if (Penable) begin
          en_cyc++;
          acc++;
        end
        Pready  = Penable && (acc == waits + 1);
        Pslverr = Pready && err;
        Prdata  = Pready ? rd : $urandom;
        if (c >= 1) Hwdata = $urandom;
        @(posedge Hclk); #1;
      end
    end
    Pready = 1'b0; Pslverr = 1'b0;
    chk("completion_seen", 32'(done), 32'd1);
    chk("hready_low_cycles", 32'(low), 32'(exp_low));
    chk("pselx_cycles", 32'(sel_cyc), 32'(exp_sel));
    chk("penable_cycles", 32'(en_cyc), 32'(exp_en));
    chk("hresp_while_low", 32'(resp_low), resp_err ? 32'd1 : 32'd0);
    chk("hresp_at_ready", 32'(Hresp), 32'(resp_err));
    chk("hrdata", Hrdata, model_rdata);
    chk("pselx_done", 32'(Pselx), 32'd0);
  endtask

  task automatic idle_step();
    valid = 1'b0;
    @(posedge Hclk); #1;
    chk("idle_hreadyout", 32'(Hreadyout), 32'd1);
    chk("idle_hresp", 32'(Hresp), 32'd0);
  endtask

  initial begin
    bit wr, err;
    int r, waits;
    logic [2:0] sel;
    Hresetn = 1'b0; valid = 1'b0; Haddr = '0; Hwrite = 1'b0; Hwdata = '0;
    tempselx = '0; Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge Hclk); Hresetn = 1'b1;
    @(posedge Hclk); #1;

    txn(1'b0, 32'h40, 3'b010, 32'h0, 0, 1'b0, 32'hDEADBEEF);
    txn(1'b1, 32'h80, 3'b001, 32'h1234, 0, 1'b0, 32'h0);
    txn(1'b0, 32'hC4, 3'b100, 32'h0, 3, 1'b0, 32'hCAFEF00D);
    txn(1'b1, 32'h88, 3'b010, 32'h5A5A, 1, 1'b1, 32'h0);
    idle_step();
    txn(1'b0, 32'hF00, 3'b000, 32'h0, 0, 1'b0, 32'h11111111);
    idle_step();
    txn(1'b1, 32'h10, 3'b000, 32'h77, 0, 1'b0, 32'h0);
    txn(1'b0, 32'h14, 3'b001, 32'h0, 0, 1'b0, 32'h13572468);

    for (int i = 0; i < 40; i++) begin
      r     = $urandom_range(0, 6);
      sel   = (r == 0) ? 3'b000 : 3'(1 << (r % 3));
      wr    = 1'($urandom);
      err   = ($urandom_range(0, 4) == 0);
`ifdef APB_TIMEOUT_EN
      waits = $urandom_range(0, 5);
`else
      waits = $urandom_range(0, 3);
`endif
      txn(wr, $urandom, sel, $urandom, waits, err, $urandom);
      if ($urandom_range(0, 2) == 0) idle_step();
    end

`ifdef APB_TIMEOUT_EN
    txn(1'b0, 32'h200, 3'b100, 32'h0, 10, 1'b0, 32'h0BADBEEF);
    idle_step();
`endif

    // Reset asserted mid-ACCESS must clear outputs without a clock edge
    valid = 1'b1; Haddr = 32'h300; Hwrite = 1'b0; tempselx = 3'b001;
    @(posedge Hclk); #1;
    valid = 1'b0;
    @(posedge Hclk); #1;
    chk("pre_reset_penable", 32'(Penable), 32'd1);
    #2 Hresetn = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_rdata = '0;
    @(negedge Hclk); Hresetn = 1'b1;
    @(posedge Hclk); #1;
    txn(1'b0, 32'h44, 3'b010, 32'h0, 1, 1'b0, 32'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_fsm_gen.md
Name: apb_master_fsm_gen

Overview:
Parametrised next-generation APB master controller for the AHB-to-APB bridge.
- Accepts one AHB-side transfer at a time and sequences APB SETUP/ACCESS phases on up to NUM_SLV one-hot selected slaves.
- Adds APB3 PREADY wait-states and PSLVERR, mapped to a two-cycle AHB ERROR response.
- Sits between the AHB slave interface (address/select pipeline) and the APB slave bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_SLV, 3, number of APB slaves (width of Pselx/tempselx)
TIMEOUT_CYC, 16, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN)

Ports:
Hclk  in  1  clock
Hresetn  in  1  asynchronous active-low reset
valid  in  1  AHB transfer present (NONSEQ/SEQ, selected, HREADY high)
Haddr  in  ADDR_W  AHB address-phase address
Hwrite  in  1  AHB direction, 1 = write
Hwdata  in  DATA_W  AHB write data (data phase)
tempselx  in  NUM_SLV  one-hot slave select decoded from Haddr
Hreadyout  out  1  AHB ready
Hresp  out  1  0 = OKAY, 1 = ERROR
Hrdata  out  DATA_W  read data returned to AHB
Paddr  out  ADDR_W  APB address
Pwrite  out  1  APB direction
Pwdata  out  DATA_W  APB write data
Pselx  out  NUM_SLV  APB one-hot select
Penable  out  1  APB enable
Pready  in  1  muxed slave ready
Pslverr  in  1  muxed slave error
Prdata  in  DATA_W  muxed slave read data

Behaviour:
- One clock (Hclk); asynchronous active-low reset (Hresetn). All outputs are registered.
- Reset values: Hreadyout=1, Hresp=0; Hrdata, Paddr, Pwdata, Pwrite, Pselx, Penable all 0; state IDLE.
- Reset mid-transfer drops Pselx/Penable immediately; the transfer is abandoned.
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- Registered Hreadyout=1 only when the state is IDLE or ERR2. valid is sampled only in those states.
- IDLE/ERR2 with valid:
  - Latch Haddr→Paddr, Hwrite→Pwrite, tempselx→selection register.
  - Hwrite=1: go to WWAIT. Hwrite=0: go to SETUP.
  - Without valid: ERR2 goes to IDLE; IDLE holds.
- WWAIT: capture Hwdata→Pwdata; go to SETUP.
- SETUP: Pselx=latched select, Penable=0; go to ACCESS.
- ACCESS: Penable=1.
  - Pready=0: hold; all P* outputs stable.
  - Pready=1 and Pslverr=0: go to IDLE. On reads, Hrdata<=Prdata in the same edge.
  - Pready=1 and Pslverr=1: go to ERR1. Hrdata is not updated.
- Pselx and Penable deassert on the edge leaving ACCESS.
- ERR1: Hreadyout=0, Hresp=1; go to ERR2.
- ERR2: Hreadyout=1, Hresp=1.
- Latency, zero-wait transfers:
  - Read: Hreadyout low for 2 cycles.
  - Write: Hreadyout low for 3 cycles.
  - Each Pready-low cycle adds one.
- tempselx all-zero on accept: skip the APB phases, go directly to ERR1 (decode error); Pselx never asserts.
- Back-to-back: valid sampled in the completion (IDLE) cycle starts the next transfer with no bubble.
- Paddr, Pwrite, Pwdata hold their last values in IDLE (no clearing).

Optional Feature:
APB_TIMEOUT_EN
- Defined: a counter clears on entering ACCESS and increments each ACCESS cycle with Pready=0. On reaching TIMEOUT_CYC-1 with Pready still 0, Pselx/Penable drop and the FSM goes to ERR1.
- Undefined: no counter exists, and ACCESS waits indefinitely for Pready.

Decomposition:
- Package apb_bridge_pkg holds:
  - state enum apb_state_e (3-bit);
  - HRESP_OKAY/HRESP_ERROR constants;
  - default width localparams.
- One sub-module, apb_timeout_cnt (counter plus expired flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Read, Haddr=0x40, tempselx=3'b010, Pready=1: Pselx=010 for 2 cycles, Penable in the 2nd. Hrdata=0xDEADBEEF and Hreadyout=1 in the 3rd cycle.
- Write, Haddr=0x80, Hwdata=0x1234 on the next cycle, Pready=1: Pwdata=0x1234 and Pwrite=1 through SETUP/ACCESS; Hreadyout low for 3 cycles.
- Read with Pready low for 3 ACCESS cycles: P* stable; Hreadyout low for 5 cycles total.
- Write with Pslverr=1 at Pready: Hresp=1 with Hreadyout=0, then Hresp=1 with Hreadyout=1, then Hresp=0.
- tempselx=000: ERR1/ERR2 sequence follows; Pselx stays 0.
- With APB_TIMEOUT_EN, TIMEOUT_CYC=4, Pready stuck 0: Penable drops after 4 ACCESS cycles, then the error response. Also assert Hresetn low mid-ACCESS: all outputs return to reset values asynchronously.
